// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption datapath: one cipher round per clock, fed by an
// externally expanded 1408-bit key schedule.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  // Multiplicative inverse as x^254 (maps 0 to 0), then the FIPS-197 affine map.
  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_round_engine #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [1407:0] exp_key,
  input  logic          start,
  input  logic [127:0]  plaintext,
  output logic          busy,
  output logic          done,
  output logic [127:0]  ciphertext
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm;
  logic [127:0] state_reg;
  logic [3:0]   round_cnt;
  logic [127:0] rk_sel;
  logic [127:0] sb_out;
  logic [127:0] sr_out;
  logic [127:0] mc_out;
  logic [127:0] round_out;
  logic         last_round;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    rk_sel = '0;
    for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
      if (round_cnt == 4'(i)) rk_sel = exp_key[1407-128*i -: 128];
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (state_reg[127-8*g -: 8]),
      .out_byte (sb_out[127-8*g -: 8])
    );
  end

  // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
  always_comb begin
    sr_out = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr_out[127-8*(r+4*c) -: 8] = sb_out[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
  end

  always_comb begin
    mc_out = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      mc_out[127-32*c -: 32] = mix_col(sr_out[127-32*c -: 32]);
    end
  end

  assign last_round = (round_cnt == 4'(NUM_ROUNDS));
  assign round_out  = (last_round ? sr_out : mc_out) ^ rk_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      state_reg  <= '0;
      round_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ciphertext <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          done <= 1'b0;
          if (start && key_valid) begin
            state_reg <= plaintext ^ exp_key[1407 -: 128];
            round_cnt <= 4'd1;
            busy      <= 1'b1;
            fsm       <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          if (last_round) begin
            ciphertext <= round_out;
            round_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            fsm        <= DONE;
          end else begin
            round_cnt <= round_cnt + 4'd1;
          end
        end
        DONE: begin
          done <= 1'b0;
          fsm  <= IDLE;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
          fsm  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Scoreboard bench for aes_round_engine using FIPS-197 and common known-answer vectors.
`timescale 1ns/1ps

module tb_aes_round_engine;

  logic          tb_clk;
  logic          rst;
  logic          key_valid;
  logic [1407:0] exp_key;
  logic          start;
  logic [127:0]  plaintext;
  logic          busy;
  logic          done;
  logic [127:0]  ciphertext;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  logic [127:0] exp_q[$];
  int           t_q[$];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] P2 = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] C2 = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  aes_round_engine #(.NUM_ROUNDS(10)) dut (
    .clk        (tb_clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .exp_key    (exp_key),
    .start      (start),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  always @(posedge tb_clk) cyc <= cyc + 1;

  function automatic logic [7:0] sub_b(input logic [7:0] b);
    return SBOX_T[2047-8*int'(b) -: 8];
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w[0:43];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] r;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sub_b(t[23:16]), sub_b(t[15:8]), sub_b(t[7:0]), sub_b(t[31:24])} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every done pulse.
  always @(negedge tb_clk) begin
    if (!rst && done) begin
      done_cnt++;
      check("busy_in_done", {127'b0, busy}, 128'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 128'd1, 128'd0);
      end else begin
        check("ciphertext", ciphertext, exp_q.pop_front());
        check("latency", 128'(cyc - t_q.pop_front()), 128'd10);
      end
    end
  end

  task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct,
                           input bit chk_hold, input logic [127:0] held);
    int d0;
    bit seen;
    @(negedge tb_clk);
    exp_key   = expand(key);
    plaintext = pt;
    key_valid = 1'b1;
    start     = 1'b1;
    exp_q.push_back(ct);
    t_q.push_back(cyc + 1);
    d0 = done_cnt;
    @(negedge tb_clk);
    start = 1'b0;
    #1 check("busy_run", {127'b0, busy}, 128'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (chk_hold) check("ct_hold", ciphertext, held);
      @(negedge tb_clk);
      #1 seen = (done_cnt != d0);
    end
    check("done_seen", 128'(done_cnt - d0), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; key_valid = 1'b0; exp_key = '0; plaintext = '0;
    repeat (2) @(negedge tb_clk);
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_done", {127'b0, done}, 128'd0);
    check("rst_ct", ciphertext, 128'd0);
    rst = 1'b0;

    run_block(K1, P1, C1, 1'b0, '0);

    // Asynchronous reset mid-cycle clears the held ciphertext immediately.
    @(negedge tb_clk);
    #2 rst = 1'b1;
    #1 check("async_rst_ct", ciphertext, 128'd0);
    check("async_rst_busy", {127'b0, busy}, 128'd0);
    @(negedge tb_clk);
    rst = 1'b0;

    run_block(K2, P2, C2, 1'b0, '0);

    // Starts while busy and in DONE must be ignored.
    @(negedge tb_clk);
    exp_key = expand(KB); plaintext = PB; key_valid = 1'b1; start = 1'b1;
    exp_q.push_back(CB);
    t_q.push_back(cyc + 1);
    d0 = done_cnt;
    for (int k = 1; k <= 13; k++) begin
      @(negedge tb_clk);
      start = (k == 3 || k == 10 || k == 11);
    end
    repeat (14) @(negedge tb_clk);
    #1 check("ign_single_done", 128'(done_cnt - d0), 128'd1);
    check("ign_idle_busy", {127'b0, busy}, 128'd0);

    // Starts with no valid key schedule.
    key_valid = 1'b0;
    start = 1'b1;
    d0 = done_cnt;
    repeat (3) begin
      @(negedge tb_clk);
      #1 check("kv0_busy", {127'b0, busy}, 128'd0);
    end
    start = 1'b0;
    repeat (14) @(negedge tb_clk);
    #1 check("kv0_no_done", 128'(done_cnt - d0), 128'd0);

    // Reset during round 5 aborts the block.
    @(negedge tb_clk);
    exp_key = expand(K1); plaintext = P1; key_valid = 1'b1; start = 1'b1;
    exp_q.push_back(C1);
    t_q.push_back(cyc + 1);
    @(negedge tb_clk);
    start = 1'b0;
    repeat (4) @(negedge tb_clk);
    #2 rst = 1'b1;
    exp_q.delete();
    t_q.delete();
    #1 check("midrst_busy", {127'b0, busy}, 128'd0);
    check("midrst_ct", ciphertext, 128'd0);
    d0 = done_cnt;
    repeat (2) @(negedge tb_clk);
    rst = 1'b0;
    repeat (15) @(negedge tb_clk);
    #1 check("midrst_no_done", 128'(done_cnt - d0), 128'd0);

    run_block(K1, P1, C1, 1'b0, '0);

    // Back-to-back blocks; ciphertext must hold the prior result until each done.
    run_block(KB, PB, CB, 1'b1, C1);
    run_block(K2, P2, C2, 1'b1, CB);

    repeat (3) @(negedge tb_clk);
    #1 check("sb_empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
